pipeline_stage_3: RTL and testbench

PIPELINE_STAGE_3 -- requirements
Module: pipeline_stage_3

---
 rtl/pipeline_stage_3.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_pipeline_stage_3.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_3.sv
// pipeline_stage_3 -- EX stage of a 5-stage MIPS-style pipeline.
//
// Purpose: selects forwarded operands, runs the ALU, and registers the
// EX/MEM pipeline word. It also owns the HI/LO registers, written by a
// single-cycle multiply or by a 32-step restoring divider. The divider
// holds the front of the pipe through Div_Stall while it runs.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   IDEX_EX/M/WB              control words from ID/EX
//   IDEX_SA/TA/DA             source, target and destination register addresses
//   IDEX_SE/PC/S/T            sign-extended immediate, PC, S and T operands
//   WB_Data/WB_Addr/WB_D_EN   MEM/WB write-back bus (forwarding source)
//   Flush                     kill the EX contents
//   EXMEM_M/WB/ALU/T/DA/Flags EX/MEM pipeline register ({Z,N,C,V} flags)
//   HI, LO                    multiply/divide result registers
//   Div_Stall                 freeze PC and IF/ID, bubble ID/EX
//   div_state_o               divider FSM state (0 = IDLE, 1 = DIV)
//
// Handshake: there is no valid/ready pair here. Div_Stall is the only
// flow control. While it is high the upstream stages hold. The ID/EX word
// presented during a stall is ignored, except in the first cycle of a
// divide, when that word is the divide being accepted.
module pipeline_stage_3 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IDEX_EX,
  input  logic [15:0] IDEX_M,
  input  logic [3:0]  IDEX_WB,
  input  logic [4:0]  IDEX_SA,
  input  logic [4:0]  IDEX_TA,
  input  logic [4:0]  IDEX_DA,
  input  logic [31:0] IDEX_SE,
  input  logic [31:0] IDEX_PC,
  input  logic [31:0] IDEX_S,
  input  logic [31:0] IDEX_T,
  input  logic [31:0] WB_Data,
  input  logic [4:0]  WB_Addr,
  input  logic        WB_D_EN,
  input  logic        Flush,
  output logic [15:0] EXMEM_M,
  output logic [3:0]  EXMEM_WB,
  output logic [31:0] EXMEM_ALU,
  output logic [31:0] EXMEM_T,
  output logic [4:0]  EXMEM_DA,
  output logic [3:0]  EXMEM_Flags,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Div_Stall,
  output logic        div_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} div_state_t;

  // Control decode
  logic [4:0] alu_op;
  logic       b_sel, is_mul, is_div, is_signed, is_link;
  logic [1:0] dest_sel;
  logic       unused_ex_hi;

  assign alu_op    = IDEX_EX[4:0];
  assign b_sel     = IDEX_EX[5];
  assign dest_sel  = IDEX_EX[7:6];
  assign is_mul    = IDEX_EX[8];
  assign is_div    = IDEX_EX[9];
  assign is_signed = IDEX_EX[10];
  assign is_link   = IDEX_EX[11];
  assign unused_ex_hi = ^IDEX_EX[15:12];

  // Registers
  div_state_t state_q;
  logic [4:0]  cnt_q;
  logic [15:0] exmem_m_q;
  logic [3:0]  exmem_wb_q;
  logic [31:0] exmem_alu_q, exmem_t_q;
  logic [4:0]  exmem_da_q;
  logic [3:0]  exmem_flags_q;
  logic [31:0] hi_q, lo_q;
  // Divider working set
  logic [31:0] quo_q, rem_q, dvsr_q;
  logic        neg_quo_q, neg_rem_q, div_zero_q;
  logic [15:0] div_m_q;
  logic [3:0]  div_wb_q;
  logic [4:0]  div_da_q;

  // Forwarding: EX/MEM wins over MEM/WB. Register 0 is never forwarded.
  logic [31:0] fwd_a, fwd_t;
  always_comb begin
    fwd_a = IDEX_S;
    if (EXMEM_WB[0] && (EXMEM_DA != 5'd0) && (EXMEM_DA == IDEX_SA))
      fwd_a = EXMEM_ALU;
    else if (WB_D_EN && (WB_Addr != 5'd0) && (WB_Addr == IDEX_SA))
      fwd_a = WB_Data;
    fwd_t = IDEX_T;
    if (EXMEM_WB[0] && (EXMEM_DA != 5'd0) && (EXMEM_DA == IDEX_TA))
      fwd_t = EXMEM_ALU;
    else if (WB_D_EN && (WB_Addr != 5'd0) && (WB_Addr == IDEX_TA))
      fwd_t = WB_Data;
  end

  logic [31:0] op_b;
  logic [4:0]  shamt;
  assign op_b  = b_sel ? IDEX_SE : fwd_t;
  assign shamt = IDEX_SE[10:6];

  // ALU
  logic [32:0] add_full, sub_full;
  logic [31:0] alu_res;
  logic        c_flag, v_flag;
  assign add_full = {1'b0, fwd_a} + {1'b0, op_b};
  // Bit 32 of the 33-bit difference is set exactly when a borrow occurs.
  assign sub_full = {1'b0, fwd_a} - {1'b0, op_b};

  always_comb begin
    alu_res = fwd_a;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    case (alu_op)
      5'd0: begin
        alu_res = add_full[31:0];
        c_flag  = add_full[32];
        v_flag  = (fwd_a[31] == op_b[31]) && (add_full[31] != fwd_a[31]);
      end
      5'd1: begin
        alu_res = sub_full[31:0];
        c_flag  = sub_full[32];
        v_flag  = (fwd_a[31] != op_b[31]) && (sub_full[31] != fwd_a[31]);
      end
      5'd2:  alu_res = fwd_a & op_b;
      5'd3:  alu_res = fwd_a | op_b;
      5'd4:  alu_res = fwd_a ^ op_b;
      5'd5:  alu_res = ~(fwd_a | op_b);
      5'd6:  alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
      5'd7:  alu_res = {31'd0, fwd_a < op_b};
      5'd8:  alu_res = op_b << shamt;
      5'd9:  alu_res = op_b >> shamt;
      5'd10: alu_res = $signed(op_b) >>> shamt;
      5'd11: alu_res = {op_b[15:0], 16'h0000};
      5'd12: alu_res = hi_q;
      5'd13: alu_res = lo_q;
      default: alu_res = fwd_a;
    endcase
  end

  // Link overrides the ALU with the PC. Carry and overflow belong to the
  // ALU add/sub only, so they are cleared for a link.
  logic [31:0] result;
  logic [3:0]  flags;
  assign result = is_link ? IDEX_PC : alu_res;
  assign flags  = {result == 32'd0, result[31],
                   c_flag & ~is_link, v_flag & ~is_link};

  logic [4:0] dest_addr;
  always_comb begin
    case (dest_sel)
      2'b00:   dest_addr = IDEX_DA;
      2'b01:   dest_addr = IDEX_TA;
      2'b10:   dest_addr = 5'd31;
      default: dest_addr = 5'd29;
    endcase
  end

  // Multiply: operands are extended to 64 bits, so one multiplier serves
  // both the signed and the unsigned case.
  logic [63:0] prod;
  logic [63:0] ext_a, ext_t;
  assign ext_a = {{32{is_signed & fwd_a[31]}}, fwd_a};
  assign ext_t = {{32{is_signed & fwd_t[31]}}, fwd_t};
  assign prod  = ext_a * ext_t;

  // Divider setup: magnitudes and sign flags for the operand pair
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = is_signed & fwd_a[31];
  assign b_neg = is_signed & fwd_t[31];
  assign a_mag = a_neg ? -fwd_a : fwd_a;
  assign b_mag = b_neg ? -fwd_t : fwd_t;

  // One restoring step. The dividend shifts out of quo_q from the MSB
  // while quotient bits shift in at the LSB.
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_nx, quo_nx, quo_fin, rem_fin;
  assign rem_sh  = {rem_q, quo_q[31]};
  assign rem_ge  = rem_sh >= {1'b0, dvsr_q};
  // When the subtract happens the difference is below the divisor, so the
  // low 32 bits hold all of it.
  assign rem_nx  = rem_ge ? (rem_sh[31:0] - dvsr_q) : rem_sh[31:0];
  assign quo_nx  = {quo_q[30:0], rem_ge};
  assign quo_fin = div_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_nx : quo_nx);
  assign rem_fin = neg_rem_q ? -rem_nx : rem_nx;

  assign Div_Stall = (state_q == S_DIV) | ((state_q == S_IDLE) & is_div & ~Flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 5'd0;
      exmem_m_q     <= 16'd0;
      exmem_wb_q    <= 4'd0;
      exmem_alu_q   <= 32'd0;
      exmem_t_q     <= 32'd0;
      exmem_da_q    <= 5'd0;
      exmem_flags_q <= 4'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      quo_q         <= 32'd0;
      rem_q         <= 32'd0;
      dvsr_q        <= 32'd0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      div_zero_q    <= 1'b0;
      div_m_q       <= 16'd0;
      div_wb_q      <= 4'd0;
      div_da_q      <= 5'd0;
    end else begin
      // EX/MEM defaults to a bubble. Only the normal-issue and
      // divide-done paths load it.
      exmem_m_q     <= 16'd0;
      exmem_wb_q    <= 4'd0;
      exmem_alu_q   <= 32'd0;
      exmem_t_q     <= 32'd0;
      exmem_da_q    <= 5'd0;
      exmem_flags_q <= 4'd0;
      case (state_q)
        S_IDLE: begin
          if (!Flush && is_div) begin
            quo_q      <= a_mag;
            rem_q      <= 32'd0;
            dvsr_q     <= b_mag;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= (fwd_t == 32'd0);
            div_m_q    <= IDEX_M;
            div_wb_q   <= IDEX_WB;
            div_da_q   <= dest_addr;
            cnt_q      <= 5'd0;
            state_q    <= S_DIV;
          end else if (!Flush) begin
            exmem_m_q     <= IDEX_M;
            exmem_wb_q    <= IDEX_WB;
            exmem_alu_q   <= result;
            exmem_t_q     <= fwd_t;
            exmem_da_q    <= dest_addr;
            exmem_flags_q <= flags;
            if (is_mul) begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end
          end
        end
        S_DIV: begin
          if (Flush) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
          end else begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              lo_q       <= quo_fin;
              hi_q       <= rem_fin;
              exmem_m_q  <= div_m_q;
              exmem_wb_q <= div_wb_q;
              exmem_da_q <= div_da_q;
              cnt_q      <= 5'd0;
              state_q    <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign EXMEM_M     = exmem_m_q;
  assign EXMEM_WB    = exmem_wb_q;
  assign EXMEM_ALU   = exmem_alu_q;
  assign EXMEM_T     = exmem_t_q;
  assign EXMEM_DA    = exmem_da_q;
  assign EXMEM_Flags = exmem_flags_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign div_state_o = state_q;

endmodule

// File: tb/tb_pipeline_stage_3.sv
// tb_pipeline_stage_3 -- directed bench for the EX stage: ALU ops and flags,
// forwarding priority, destination select, multiply, divide, flush, and
// reset during a divide.
module tb_pipeline_stage_3;

  logic        clk, rst;
  logic [15:0] IDEX_EX, IDEX_M;
  logic [3:0]  IDEX_WB;
  logic [4:0]  IDEX_SA, IDEX_TA, IDEX_DA;
  logic [31:0] IDEX_SE, IDEX_PC, IDEX_S, IDEX_T;
  logic [31:0] WB_Data;
  logic [4:0]  WB_Addr;
  logic        WB_D_EN, Flush;
  logic [15:0] EXMEM_M;
  logic [3:0]  EXMEM_WB;
  logic [31:0] EXMEM_ALU, EXMEM_T;
  logic [4:0]  EXMEM_DA;
  logic [3:0]  EXMEM_Flags;
  logic [31:0] HI, LO;
  logic        Div_Stall, div_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  pipeline_stage_3 dut (
    .clk(clk), .rst(rst),
    .IDEX_EX(IDEX_EX), .IDEX_M(IDEX_M), .IDEX_WB(IDEX_WB),
    .IDEX_SA(IDEX_SA), .IDEX_TA(IDEX_TA), .IDEX_DA(IDEX_DA),
    .IDEX_SE(IDEX_SE), .IDEX_PC(IDEX_PC), .IDEX_S(IDEX_S), .IDEX_T(IDEX_T),
    .WB_Data(WB_Data), .WB_Addr(WB_Addr), .WB_D_EN(WB_D_EN), .Flush(Flush),
    .EXMEM_M(EXMEM_M), .EXMEM_WB(EXMEM_WB), .EXMEM_ALU(EXMEM_ALU),
    .EXMEM_T(EXMEM_T), .EXMEM_DA(EXMEM_DA), .EXMEM_Flags(EXMEM_Flags),
    .HI(HI), .LO(LO), .Div_Stall(Div_Stall), .div_state_o(div_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One non-forwarding ALU instruction; expected result goes through exp_q.
  task automatic run_alu(input string tag, input logic [15:0] ex, input logic [31:0] s,
                         input logic [31:0] t, input logic [31:0] se,
                         input logic [31:0] e_alu, input logic [3:0] e_flags);
    IDEX_EX = ex; IDEX_S = s; IDEX_T = t; IDEX_SE = se;
    IDEX_SA = 5'd0; IDEX_TA = 5'd0; IDEX_DA = 5'd0; IDEX_M = 16'd0; IDEX_WB = 4'd0;
    exp_q.push_back(e_alu);
    tick();
    chk({tag, "_alu"}, EXMEM_ALU, exp_q.pop_front());
    chk({tag, "_flags"}, EXMEM_Flags, e_flags);
  endtask

  // Issue a divide and count the cycles Div_Stall stays high, with a bound.
  task automatic run_div(input logic [15:0] ex, input logic [31:0] s, input logic [31:0] t,
                         output int cycles);
    IDEX_EX = ex; IDEX_S = s; IDEX_T = t; IDEX_SA = 5'd0; IDEX_TA = 5'd0;
    #1;
    cycles = 0;
    while (Div_Stall && cycles < 100) begin
      tick();
      cycles++;
      if (cycles == 1) IDEX_EX = 16'd0;
      if (cycles == 5) chk("div_bubble_m", EXMEM_M, 16'd0);
    end
  endtask

  int cyc;

  initial begin
    rst = 1'b1; Flush = 1'b0;
    IDEX_EX = 16'd0; IDEX_M = 16'd0; IDEX_WB = 4'd0;
    IDEX_SA = 5'd0; IDEX_TA = 5'd0; IDEX_DA = 5'd0;
    IDEX_SE = 32'd0; IDEX_PC = 32'd0; IDEX_S = 32'd0; IDEX_T = 32'd0;
    WB_Data = 32'd0; WB_Addr = 5'd0; WB_D_EN = 1'b0;
    tick(); tick();
    chk("rst_alu", EXMEM_ALU, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_stall", Div_Stall, 1'b0);
    chk("rst_state", div_state, 1'b0);
    rst = 1'b0;

    // ADD overflow, full EX/MEM word
    IDEX_EX = 16'h0000; IDEX_S = 32'h7FFFFFFF; IDEX_T = 32'd1;
    IDEX_SA = 5'd1; IDEX_TA = 5'd2; IDEX_DA = 5'd3; IDEX_M = 16'h00A5; IDEX_WB = 4'h1;
    tick();
    chk("addovf_alu", EXMEM_ALU, 32'h80000000);
    chk("addovf_flags", EXMEM_Flags, 4'b0101);
    chk("addovf_da", EXMEM_DA, 5'd3);
    chk("addovf_m", EXMEM_M, 16'h00A5);
    chk("addovf_wb", EXMEM_WB, 4'h1);
    chk("addovf_t", EXMEM_T, 32'd1);

    // Forwarding priority: produce r5 = 0xF, then read r5 with both buses hitting
    IDEX_S = 32'd10; IDEX_T = 32'd5; IDEX_DA = 5'd5;
    tick();
    chk("fwd_setup", EXMEM_ALU, 32'hF);
    IDEX_EX = 16'h000E; IDEX_SA = 5'd5; IDEX_TA = 5'd5; IDEX_S = 32'h999; IDEX_T = 32'h888;
    IDEX_DA = 5'd0; WB_D_EN = 1'b1; WB_Addr = 5'd5; WB_Data = 32'h100;
    tick();
    chk("fwd_exmem_a", EXMEM_ALU, 32'hF);
    chk("fwd_exmem_t", EXMEM_T, 32'hF);
    tick();
    chk("fwd_wb_a", EXMEM_ALU, 32'h100);
    chk("fwd_wb_t", EXMEM_T, 32'h100);
    WB_D_EN = 1'b0; WB_Addr = 5'd0;

    // ALU table
    run_alu("sub_borrow", 16'h0021, 32'd1, 32'd0, 32'd2, 32'hFFFFFFFF, 4'b0110);
    run_alu("sub_zero", 16'h0001, 32'd5, 32'd5, 32'd0, 32'd0, 4'b1000);
    run_alu("add_carry", 16'h0000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'b1010);
    run_alu("and", 16'h0002, 32'hF0F0, 32'hFF00, 32'd0, 32'hF000, 4'b0000);
    run_alu("or", 16'h0003, 32'hF0F0, 32'hFF00, 32'd0, 32'hFFF0, 4'b0000);
    run_alu("xor", 16'h0004, 32'hF0F0, 32'hFF00, 32'd0, 32'h0FF0, 4'b0000);
    run_alu("nor", 16'h0005, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 4'b0100);
    run_alu("slt", 16'h0006, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 4'b0000);
    run_alu("sltu", 16'h0007, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'b1000);
    run_alu("sll", 16'h0008, 32'd0, 32'd1, 32'h100, 32'h10, 4'b0000);
    run_alu("srl", 16'h0009, 32'd0, 32'h80000000, 32'h100, 32'h08000000, 4'b0000);
    run_alu("sra", 16'h000A, 32'd0, 32'h80000000, 32'h100, 32'hF8000000, 4'b0100);
    run_alu("lui", 16'h002B, 32'd0, 32'd0, 32'h1234, 32'h12340000, 4'b0000);
    run_alu("pass14", 16'h000E, 32'hABCD, 32'd7, 32'd0, 32'hABCD, 4'b0000);

    // Destination select and link
    IDEX_TA = 5'd9; IDEX_DA = 5'd3;
    IDEX_EX = 16'h0040; tick(); chk("dest_ta", EXMEM_DA, 5'd9);
    IDEX_EX = 16'h00C0; tick(); chk("dest_29", EXMEM_DA, 5'd29);
    IDEX_PC = 32'h400; IDEX_EX = 16'h0880; tick();
    chk("link_alu", EXMEM_ALU, 32'h400);
    chk("link_da", EXMEM_DA, 5'd31);
    IDEX_TA = 5'd0;

    // Multiply signed and unsigned, then read back via MFHI/MFLO
    IDEX_EX = 16'h0500; IDEX_S = 32'hFFFFFFFD; IDEX_T = 32'd5; tick();
    chk("muls_hi", HI, 32'hFFFFFFFF);
    chk("muls_lo", LO, 32'hFFFFFFF1);
    IDEX_EX = 16'h0100; IDEX_S = 32'h10000; IDEX_T = 32'h10000; tick();
    chk("mulu_hi", HI, 32'd1);
    chk("mulu_lo", LO, 32'd0);
    run_alu("mfhi", 16'h000C, 32'd0, 32'd0, 32'd0, 32'd1, 4'b0000);
    run_alu("mflo", 16'h000D, 32'd5, 32'd0, 32'd0, 32'd0, 4'b1000);
    IDEX_EX = 16'h0100; IDEX_S = 32'd2; IDEX_T = 32'd3; Flush = 1'b1; tick();
    chk("mulflush_hi", HI, 32'd1);
    chk("mulflush_lo", LO, 32'd0);
    chk("mulflush_alu", EXMEM_ALU, 32'd0);
    Flush = 1'b0;

    // Signed divide -7 / 2
    IDEX_M = 16'h0033; IDEX_WB = 4'h1; IDEX_DA = 5'd7;
    run_div(16'h0600, 32'hFFFFFFF9, 32'd2, cyc);
    chk("divs_cycles", cyc, 33);
    chk("divs_lo", LO, 32'hFFFFFFFD);
    chk("divs_hi", HI, 32'hFFFFFFFF);
    chk("divs_m", EXMEM_M, 16'h0033);
    chk("divs_wb", EXMEM_WB, 4'h1);
    chk("divs_da", EXMEM_DA, 5'd7);
    chk("divs_alu", EXMEM_ALU, 32'd0);
    chk("divs_flags", EXMEM_Flags, 4'd0);

    // Divide by zero
    run_div(16'h0200, 32'd100, 32'd0, cyc);
    chk("div0_cycles", cyc, 33);
    chk("div0_lo", LO, 32'hFFFFFFFF);
    chk("div0_hi", HI, 32'd100);

    // Flush at cycle 10 of a divide
    IDEX_EX = 16'h0200; IDEX_S = 32'd50; IDEX_T = 32'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) IDEX_EX = 16'd0;
    end
    Flush = 1'b1; IDEX_M = 16'h0077; IDEX_WB = 4'hF; IDEX_DA = 5'd5;
    #1 chk("flush_stall_hold", Div_Stall, 1'b1);
    tick();
    Flush = 1'b0;
    #1;
    chk("flush_stall", Div_Stall, 1'b0);
    chk("flush_state", div_state, 1'b0);
    chk("flush_hi", HI, 32'd100);
    chk("flush_lo", LO, 32'hFFFFFFFF);
    chk("flush_m", EXMEM_M, 16'd0);
    chk("flush_wb", EXMEM_WB, 4'd0);
    chk("flush_da", EXMEM_DA, 5'd0);

    // Reset in the middle of a divide
    IDEX_M = 16'd0; IDEX_WB = 4'd0; IDEX_DA = 5'd0;
    IDEX_EX = 16'h0200; IDEX_S = 32'd9; IDEX_T = 32'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) IDEX_EX = 16'd0;
    end
    chk("prerst_state", div_state, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    chk("midrst_alu", EXMEM_ALU, 32'd0);
    chk("midrst_m", EXMEM_M, 16'd0);
    chk("midrst_state", div_state, 1'b0);
    chk("midrst_stall", Div_Stall, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
